pulse_win_sampler: RTL
======================

Name: pulse_win_sampler

Overview:
- Windowed rate sampler that drives a free-running pulse counter (CNT_WIDTH counter with clear `clc` and pulse input `d_i`) and consumes its count.
- Divides time into contiguous windows of programmable length and clears the counter at each window boundary.
- Captures each window's pulse total without losing pulses and presents it on a valid/ready sample port.
- Keeps a running maximum and a count of dropped samples.

Parameters:
- CNT_WIDTH, 32, width of the counter value consumed and of the sample data.
- WIN_WIDTH, 32, width of the window-length timer.
- SEQ_WIDTH, 8, width of the sample sequence number.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; synchronous, active-low.
- en_i  input  1  enable windowing.
- win_len_i  input  WIN_WIDTH  window length in cycles; 0 is invalid.
- d_i  input  1  pulse tap, the same signal that feeds the counter.
- cnt_i  input  CNT_WIDTH  counter value (registered output of the counter).
- clc_o  output  1  clear to the counter.
- smp_data_o  output  CNT_WIDTH  window pulse total.
- smp_seq_o  output  SEQ_WIDTH  sample sequence number.
- smp_valid_o  output  1  sample valid.
- smp_ready_i  input  1  sample accepted.
- max_o  output  CNT_WIDTH  largest window total since the last clear.
- drop_cnt_o  output  16  samples dropped due to backpressure; saturating.
- stat_clr_i  input  1  clears max_o and drop_cnt_o.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, timer=0, len_q=0.
  - smp_data_o=0, smp_seq_o=0, smp_valid_o=0, max_o=0, drop_cnt_o=0.
  - clc_o=1 while in reset and on the first cycle after reset.
  - Reset mid-window aborts the window with no sample.
- clc_o = (state==IDLE) | win_end, where win_end = (state==RUN) & (timer==len_q-1).
  - clc_o is decoded from registers only; there is no combinational path from any input.
- IDLE:
  - Counter is held cleared.
  - When en_i=1 and win_len_i!=0: len_q<=win_len_i, timer<=0, go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - The window covers RUN cycles with timer=0..len_q-1.
  - On timer==0 the counter reads 0, because it was cleared by the previous clc_o.
  - While timer<len_q-1: timer increments.
  - On win_end:
    - total = cnt_i + d_i. The d_i of the end cycle is lost by the counter (clear has priority) and must be added here.
    - total saturates at all-ones.
    - timer<=0.
    - len_q<=win_len_i, so a new length applies only from the next window.
    - Stay in RUN. Windows are back-to-back; every pulse lands in exactly one window.
  - win_len_i==0 at a window end → go to IDLE after emitting the sample.
  - en_i=0 in any RUN cycle → go to IDLE next cycle. The current window is discarded with no sample, including when en_i=0 on a win_end cycle.
  - win_len 1: every RUN cycle is win_end; total = d_i.
- Sample port:
  - On win_end, if smp_valid_o==0 or smp_ready_i==1:
    - smp_data_o<=total, smp_seq_o<=smp_seq_o+1 (wraps modulo 2^SEQ_WIDTH), smp_valid_o<=1.
    - The first sample after reset carries seq 1.
  - On win_end while smp_valid_o=1 and smp_ready_i=0:
    - Hold the old sample; the new total is discarded.
    - drop_cnt_o increments, saturating at 0xFFFF.
    - smp_seq_o still increments internally, so the receiver sees the gap. The output register shows the seq of the held sample.
  - smp_valid_o & smp_ready_i with no win_end → smp_valid_o<=0.
  - Data and seq are stable while valid=1 and ready=0.
- Statistics:
  - max_o<=total if total>max_o, on every win_end including dropped samples.
  - stat_clr_i=1 → max_o<=0, drop_cnt_o<=0. Clear has priority over a same-cycle update; the sample itself is still delivered.
- Latency: the sample is visible (smp_valid_o=1) on the cycle after win_end.

Test Plan:
- Basic window: win_len=10, d_i=1 every cycle, ready=1 → samples of 10 on consecutive windows, seq 1,2,3, clc_o high once per 10 cycles.
- Boundary pulse: win_len=4, single pulse only on the win_end cycle → sample=1, next window sample=0; total over 8 windows equals injected pulses.
- Backpressure: ready=0, win_len=5, 3 windows → first sample held at seq 1, drop_cnt_o=2; ready=1 then next sample seq 4.
- Length change and win_len=1: switch 8→3 mid-window → current window is 8 cycles, then 3; win_len=1 with d_i=1 → sample=1 each cycle.
- Abort and reset: en_i=0 at timer=5 of 10 → no sample, clc_o=1 next cycle; rst_n=0 mid-window → all outputs 0, clc_o=1.
- Saturation and stats: CNT_WIDTH=4, cnt_i=15, d_i=1 at win_end → sample=15; max_o tracks peak; stat_clr_i same cycle as win_end → max_o=0, sample still delivered.

Source files
------------

// File: rtl/pulse_win_sampler.sv
// rtl/pulse_win_sampler.sv - windowed pulse-rate sampler with valid/ready sample port and stats
module pulse_win_sampler #(
    parameter int CNT_WIDTH = 32,
    parameter int WIN_WIDTH = 32,
    parameter int SEQ_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en_i,
    input  logic [WIN_WIDTH-1:0] win_len_i,
    input  logic                 d_i,
    input  logic [CNT_WIDTH-1:0] cnt_i,
    output logic                 clc_o,
    output logic [CNT_WIDTH-1:0] smp_data_o,
    output logic [SEQ_WIDTH-1:0] smp_seq_o,
    output logic                 smp_valid_o,
    input  logic                 smp_ready_i,
    output logic [CNT_WIDTH-1:0] max_o,
    output logic [15:0]          drop_cnt_o,
    input  logic                 stat_clr_i
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [WIN_WIDTH-1:0] timer;
    logic [WIN_WIDTH-1:0] timer_nxt;
    logic [WIN_WIDTH-1:0] len_q;
    logic [WIN_WIDTH-1:0] len_nxt;
    logic [SEQ_WIDTH-1:0] seq_q;
    logic                 win_end;
    logic                 smp_ev;
    logic                 accept;
    logic [CNT_WIDTH:0]   sum;
    logic [CNT_WIDTH-1:0] total;

    // Window boundary is decoded from registers only, so clc_o never depends on an input.
    assign win_end = (state == RUN) && (timer == (len_q - WIN_WIDTH'(1)));
    assign clc_o   = (state == IDLE) | win_end;

    // A window that ends while en_i is low is thrown away entirely.
    assign smp_ev  = win_end & en_i;
    assign accept  = ~smp_valid_o | smp_ready_i;

    // The counter drops the end-cycle pulse (clear wins), so add it back here.
    assign sum     = {1'b0, cnt_i} + {{CNT_WIDTH{1'b0}}, d_i};
    assign total   = sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];

    // Window state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            timer <= '0;
            len_q <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            len_q <= len_nxt;
        end
    end

    // Next-state logic: back-to-back windows; new length latched only at a boundary.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        len_nxt   = len_q;
        case (state)
            IDLE: begin
                timer_nxt = '0;
                if (en_i && (win_len_i != '0)) begin
                    state_nxt = RUN;
                    len_nxt   = win_len_i;
                end
            end
            RUN: begin
                if (!en_i) begin
                    state_nxt = IDLE;
                    timer_nxt = '0;
                end else if (win_end) begin
                    timer_nxt = '0;
                    len_nxt   = win_len_i;
                    if (win_len_i == '0) begin
                        state_nxt = IDLE;
                    end
                end else begin
                    timer_nxt = timer + WIN_WIDTH'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                timer_nxt = '0;
            end
        endcase
    end

    // Internal sequence number advances on every window, delivered or dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seq_q <= '0;
        end else if (smp_ev) begin
            seq_q <= seq_q + SEQ_WIDTH'(1);
        end
    end

    // Sample output register: load when free or being drained, otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            smp_data_o  <= '0;
            smp_seq_o   <= '0;
            smp_valid_o <= 1'b0;
        end else if (smp_ev && accept) begin
            smp_data_o  <= total;
            smp_seq_o   <= seq_q + SEQ_WIDTH'(1);
            smp_valid_o <= 1'b1;
        end else if (smp_valid_o && smp_ready_i) begin
            smp_valid_o <= 1'b0;
        end
    end

    // Running maximum and saturating drop count; clear beats a same-cycle update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            max_o      <= '0;
            drop_cnt_o <= '0;
        end else if (stat_clr_i) begin
            max_o      <= '0;
            drop_cnt_o <= '0;
        end else if (smp_ev) begin
            if (total > max_o) begin
                max_o <= total;
            end
            if (!accept && (drop_cnt_o != 16'hFFFF)) begin
                drop_cnt_o <= drop_cnt_o + 16'd1;
            end
        end
    end

endmodule
